// File: rtl/bolo_scan_gen.sv
// Raster scan sequencer for the bolometer readout: coordinates, frame reset pulse, line parity, EOF interrupt.
// Optional frame counter enabled by defining SCAN_FRAME_CNT_EN.
`ifndef MODE_MATH_PED
`define MODE_MATH_PED 8'hA5
`endif

module bolo_scan_gen #(
  parameter int unsigned H_ACTIVE  = 384,
  parameter int unsigned V_ACTIVE  = 288,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned RST_PULSE = 4,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              SINGLE,
  input  logic              START,
  input  logic [31:0]       MODE,
  output logic [CNT_W-1:0]  HORIZONTAL,
  output logic [CNT_W-1:0]  VERTICAL,
  output logic              PIX_VALID,
  output logic              LINE_START,
  output logic              FRAME_START,
  output logic              CHANGE,
  output logic              RESET_BOLOMETER,
  output logic              INT_MK,
  output logic              BUSY,
  output logic [FCNT_W-1:0] FRAME_CNT
);

  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam int unsigned BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [PW-1:0]    P_LAST = PW'(RST_PULSE - 1);
  localparam logic [BW-1:0]    B_LAST = BW'((H_BLANK > 0) ? (H_BLANK - 1) : 0);

  typedef enum logic [1:0] {IDLE, FRESET, ACTIVE, HBLANK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [PW-1:0]    p_q, p_d;
  logic [BW-1:0]    b_q, b_d;
  logic             change_q, change_d;
  logic             pix_valid_q, pix_valid_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             rst_bolo_q, rst_bolo_d;
  logic             int_mk_q;
  logic             busy_q;
  logic             line_end;
  logic             frame_end;
  logic             mode_ped;
  logic             unused_mode;

  assign mode_ped    = (MODE[15:8] == `MODE_MATH_PED);
  assign unused_mode = ^{MODE[31:16], MODE[7:0]};

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      p_q           <= '0;
      b_q           <= '0;
      change_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rst_bolo_q    <= 1'b0;
      int_mk_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      p_q           <= p_d;
      b_q           <= b_d;
      change_q      <= change_d;
      pix_valid_q   <= pix_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      rst_bolo_q    <= rst_bolo_d;
      int_mk_q      <= frame_end && !mode_ped;
      busy_q        <= (state_d != IDLE);
    end
  end

  // Next state; ENABLE low in a running state leaves everything frozen
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    p_d           = p_q;
    b_d           = b_q;
    change_d      = change_q;
    pix_valid_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    line_end      = 1'b0;
    frame_end     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ENABLE && (!SINGLE || START)) begin
          state_d = FRESET;
          p_d     = '0;
          h_d     = '0;
          v_d     = '0;
        end
      end
      FRESET: begin
        if (ENABLE) begin
          if (p_q == P_LAST) begin
            state_d       = ACTIVE;
            h_d           = '0;
            v_d           = '0;
            pix_valid_d   = 1'b1;
            line_start_d  = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            p_d = p_q + PW'(1);
          end
        end
      end
      ACTIVE: begin
        if (ENABLE) begin
          if (h_q == H_LAST) begin
            change_d = ~change_q;
            if (H_BLANK > 0) begin
              state_d = HBLANK;
              b_d     = '0;
            end else begin
              line_end = 1'b1;
            end
          end else begin
            h_d         = h_q + CNT_W'(1);
            pix_valid_d = 1'b1;
          end
        end
      end
      HBLANK: begin
        if (ENABLE) begin
          if (b_q == B_LAST) begin
            line_end = 1'b1;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line advance, or frame wrap after the last line
    if (line_end) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        frame_end = 1'b1;
        v_d       = '0;
        if (!SINGLE) begin
          state_d = FRESET;
          p_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        v_d          = v_q + CNT_W'(1);
        state_d      = ACTIVE;
        pix_valid_d  = 1'b1;
        line_start_d = 1'b1;
      end
    end

    rst_bolo_d = (state_d == FRESET);
  end

`ifdef SCAN_FRAME_CNT_EN
  logic [FCNT_W-1:0] fcnt_q;

  // Completed-frame counter, counts even when the interrupt is masked
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fcnt_q <= '0;
    end else if (frame_end) begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign FRAME_CNT = fcnt_q;
`else
  assign FRAME_CNT = '0;
`endif

  assign HORIZONTAL      = h_q;
  assign VERTICAL        = v_q;
  assign PIX_VALID       = pix_valid_q;
  assign LINE_START      = line_start_q;
  assign FRAME_START     = frame_start_q;
  assign CHANGE          = change_q;
  assign RESET_BOLOMETER = rst_bolo_q;
  assign INT_MK          = int_mk_q;
  assign BUSY            = busy_q;

endmodule

// File: tb/tb_bolo_scan_gen.sv
// Bench for bolo_scan_gen: two geometries run in lockstep against a frame-position reference model.
`ifndef MODE_MATH_PED
`define MODE_MATH_PED 8'hA5
`endif

module tb_bolo_scan_gen;

  localparam int CW = 10;
  localparam int FW = 16;

  logic clk;
  logic rst_n;
  logic enable;
  logic single;
  logic start;
  logic [31:0] mode;

  logic [CW-1:0] h_a, v_a, h_b, v_b;
  logic pv_a, ls_a, fs_a, chg_a, rbo_a, int_a, busy_a;
  logic pv_b, ls_b, fs_b, chg_b, rbo_b, int_b, busy_b;
  logic [FW-1:0] fc_a, fc_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // geometry per instance: 0 = (4,3,2,2), 1 = (4,3,0,1)
  int mh [2] = '{4, 4};
  int mv [2] = '{3, 3};
  int mb [2] = '{2, 0};
  int mr [2] = '{2, 1};

  bit m_run [2];
  bit m_pause [2];
  bit m_fend [2];
  bit m_int [2];
  int m_pos [2];
  int m_lines [2];
  int m_fcnt [2];

  logic [42:0] got [2];

  bolo_scan_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .RST_PULSE(2), .CNT_W(CW), .FCNT_W(FW)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .SINGLE(single), .START(start), .MODE(mode),
    .HORIZONTAL(h_a), .VERTICAL(v_a), .PIX_VALID(pv_a), .LINE_START(ls_a), .FRAME_START(fs_a),
    .CHANGE(chg_a), .RESET_BOLOMETER(rbo_a), .INT_MK(int_a), .BUSY(busy_a), .FRAME_CNT(fc_a)
  );

  bolo_scan_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(0), .RST_PULSE(1), .CNT_W(CW), .FCNT_W(FW)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .SINGLE(single), .START(start), .MODE(mode),
    .HORIZONTAL(h_b), .VERTICAL(v_b), .PIX_VALID(pv_b), .LINE_START(ls_b), .FRAME_START(fs_b),
    .CHANGE(chg_b), .RESET_BOLOMETER(rbo_b), .INT_MK(int_b), .BUSY(busy_b), .FRAME_CNT(fc_b)
  );

  assign got[0] = {busy_a, int_a, rbo_a, chg_a, fs_a, ls_a, pv_a, v_a, h_a, fc_a};
  assign got[1] = {busy_b, int_b, rbo_b, chg_b, fs_b, ls_b, pv_b, v_b, h_b, fc_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int period(input int i);
    return mr[i] + mv[i] * (mh[i] + mb[i]);
  endfunction

  // Expected outputs from position within the frame timeline
  function automatic logic [42:0] model_out(input int i);
    int k, l, col, line;
    logic [CW-1:0] hz, vt;
    logic pv, ls, fs, rb;
    logic [FW-1:0] fc;
    hz = '0; vt = '0; pv = 1'b0; ls = 1'b0; fs = 1'b0; rb = 1'b0;
    if (m_run[i]) begin
      rb = (m_pos[i] < mr[i]);
      if (!rb) begin
        k    = m_pos[i] - mr[i];
        l    = mh[i] + mb[i];
        line = k / l;
        col  = k % l;
        hz   = CW'((col < mh[i]) ? col : mh[i] - 1);
        vt   = CW'(line);
        pv   = (col < mh[i]) && !m_pause[i];
        ls   = (col == 0) && !m_pause[i];
        fs   = (k == 0) && !m_pause[i];
      end
    end
`ifdef SCAN_FRAME_CNT_EN
    fc = FW'(m_fcnt[i]);
`else
    fc = '0;
`endif
    return {m_run[i], m_int[i], rb, m_lines[i][0], fs, ls, pv, vt, hz, fc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pause[i] = 0; m_fend[i] = 0; m_int[i] = 0;
      m_pos[i] = 0; m_lines[i] = 0; m_fcnt[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    m_fend[i]  = 0;
    m_int[i]   = 0;
    m_pause[i] = 0;
    if (!m_run[i]) begin
      if (enable && (!single || start)) begin
        m_run[i] = 1;
        m_pos[i] = 0;
      end
    end else if (!enable) begin
      m_pause[i] = 1;
    end else begin
      if (m_pos[i] >= mr[i] && ((m_pos[i] - mr[i]) % (mh[i] + mb[i])) == mh[i] - 1)
        m_lines[i]++;
      m_pos[i]++;
      if (m_pos[i] == period(i)) begin
        m_fend[i] = 1;
        m_int[i]  = (mode[15:8] != `MODE_MATH_PED);
        m_fcnt[i] = (m_fcnt[i] + 1) % (1 << FW);
        m_pos[i]  = 0;
        if (single) m_run[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; single = 1'b0; start = 1'b0; mode = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== 43'h0) begin
        bad++;
        $display("FAIL reset_values[%0d] got=%h exp=%h", i, got[i], 43'h0);
      end
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== model_out(i)) begin
        bad++;
        $display("FAIL reset_idle[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
      end
    end
  endtask

  task automatic test_continuous();
    int last_int [2];
    int pvcnt [2];
    int nint [2];
    enable = 1'b1; single = 1'b0; start = 1'b0; mode = '0;
    apply_reset();
    for (int i = 0; i < 2; i++) begin last_int[i] = -1; pvcnt[i] = 0; nint[i] = 0; end
    for (int c = 0; c < 75; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL cont[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
        if (got[i][36]) pvcnt[i]++;
        if (got[i][41]) begin
          nint[i]++;
          if (last_int[i] >= 0) begin
            total++;
            if (cyc - last_int[i] != period(i)) begin
              bad++;
              $display("FAIL cont_period[%0d] got=%0d exp=%0d", i, cyc - last_int[i], period(i));
            end
            total++;
            if (pvcnt[i] != mh[i] * mv[i]) begin
              bad++;
              $display("FAIL cont_pixels[%0d] got=%0d exp=%0d", i, pvcnt[i], mh[i] * mv[i]);
            end
          end
          last_int[i] = cyc;
          pvcnt[i]    = 0;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (nint[i] != 74 / period(i)) begin
        bad++;
        $display("FAIL cont_int_count[%0d] got=%0d exp=%0d", i, nint[i], 74 / period(i));
      end
    end
  endtask

  task automatic test_pause();
    int  last_fs;
    bit  found;
    bit  seen;
    enable = 1'b1; single = 1'b0; start = 1'b0; mode = '0;
    apply_reset();
    last_fs = -1; found = 0; seen = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL pause_pre[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
      if (fs_a) last_fs = cyc;
      if (h_a == 2 && v_a == 1 && pv_a) begin found = 1; break; end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL pause_reach got=%0d exp=1", found);
    end
    enable = 1'b0;
    repeat (5) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL pause_hold[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
      total++;
      if (pv_a !== 1'b0 || h_a !== CW'(2) || v_a !== CW'(1)) begin
        bad++;
        $display("FAIL pause_freeze got=pv%b h%0d v%0d exp=pv0 h2 v1", pv_a, h_a, v_a);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL pause_post[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
      if (fs_a) begin seen = 1; break; end
    end
    total++;
    if (!seen || cyc - last_fs != period(0) + 5) begin
      bad++;
      $display("FAIL pause_period got=%0d exp=%0d", seen ? cyc - last_fs : -1, period(0) + 5);
    end
  endtask

  task automatic test_single();
    int nint;
    enable = 1'b1; single = 1'b1; start = 1'b0; mode = '0;
    apply_reset();
    nint = 0;
    for (int c = 0; c < 45; c++) begin
      start = (c == 2 || c == 10);
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL single[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
      if (int_a) begin
        nint++;
        total++;
        if (busy_a !== 1'b0) begin
          bad++;
          $display("FAIL single_busy_at_int got=%b exp=0", busy_a);
        end
      end
    end
    total++;
    if (nint != 1) begin
      bad++;
      $display("FAIL single_once got=%0d exp=1", nint);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL single_idle_after got=%b exp=0", busy_a);
    end
  endtask

  task automatic test_mask();
    int nint;
    logic [FW-1:0] exp_fc;
    enable = 1'b1; single = 1'b0; start = 1'b0;
    mode = $urandom;
    mode[15:8] = `MODE_MATH_PED;
    apply_reset();
    nint = 0;
    for (int c = 0; c < 70; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL mask[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
      if (int_a) nint++;
    end
    total++;
    if (nint != 0) begin
      bad++;
      $display("FAIL mask_int got=%0d exp=0", nint);
    end
`ifdef SCAN_FRAME_CNT_EN
    exp_fc = FW'(3);
`else
    exp_fc = '0;
`endif
    total++;
    if (fc_a !== exp_fc) begin
      bad++;
      $display("FAIL mask_frame_cnt got=%0d exp=%0d", fc_a, exp_fc);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; single = 1'b0; start = 1'b0; mode = '0;
    apply_reset();
    repeat (8) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL rmid_pre[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== 43'h0) begin
        bad++;
        $display("FAIL rmid_async[%0d] got=%h exp=%h", i, got[i], 43'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (rbo_a !== 1'b1 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL rmid_restart got=rb%b busy%b exp=rb1 busy1", rbo_a, busy_a);
    end
    repeat (25) begin
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL rmid_post[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) single = ~single;
      start = ($urandom_range(0, 7) == 0);
      mode  = $urandom;
      if ($urandom_range(0, 3) == 0) mode[15:8] = `MODE_MATH_PED;
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_out(i)) begin
          bad++;
          $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", i, cyc, got[i], model_out(i));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; single = 1'b0; start = 1'b0; mode = '0;
    test_reset();
    test_continuous();
    test_pause();
    test_single();
    test_mask();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
